// File: rtl/mult_block_buffer.sv
// Pipelined multiplier that fills a 2**LOGDEPTH result block, then streams it back on request.
// Optional early flush of a partially filled block when MULT_FLUSH_EN is defined.
`timescale 1ns/1ps
module mult_block_buffer #(
    parameter int IN_WIDTH    = 16,
    parameter int LOGDEPTH    = 6,
    parameter int PIPE_STAGES = 3,
    parameter int SIGNED      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    EN_mult,
    input  logic [IN_WIDTH-1:0]     mult_input0,
    input  logic [IN_WIDTH-1:0]     mult_input1,
    output logic                    RDY_mult,
    output logic                    EN_writeMem,
    output logic [LOGDEPTH-1:0]     writeMem_addr,
    output logic [2*IN_WIDTH-1:0]   writeMem_val,
    input  logic                    EN_blockRead,
    output logic                    EN_readMem,
    output logic [LOGDEPTH-1:0]     readMem_addr,
    input  logic [2*IN_WIDTH-1:0]   readMem_val,
    output logic                    VALID_memVal,
    output logic [2*IN_WIDTH-1:0]   memVal_data,
    output logic [LOGDEPTH:0]       fill_count
`ifdef MULT_FLUSH_EN
    ,
    input  logic                    flush
`endif
);
    localparam int PW    = 2 * IN_WIDTH;
    localparam int DEPTH = 2 ** LOGDEPTH;
    localparam logic [LOGDEPTH:0] DEPTH_CNT = (LOGDEPTH + 1)'(DEPTH);
    localparam logic [LOGDEPTH:0] CNT_ONE   = (LOGDEPTH + 1)'(1);

    typedef enum logic [1:0] {IDLE, FILL, FULL, READ} state_t;

    state_t                  state, state_next;
    logic [LOGDEPTH:0]       acc_cnt, acc_next;
    logic                    flushed, flushed_next;
    logic                    rdy_next;
    logic                    accept;
    logic                    flush_in;
    logic                    wr_fire;
    logic                    rd_last;

`ifdef MULT_FLUSH_EN
    assign flush_in = flush;
`else
    assign flush_in = 1'b0;
`endif

    // Both modes extend to PW bits first so the low PW bits of the product are exact.
    function automatic logic signed [PW-1:0] mult_full(input logic [IN_WIDTH-1:0] a,
                                                      input logic [IN_WIDTH-1:0] b);
        logic signed [PW-1:0] ea, eb;
        if (SIGNED != 0) begin
            ea = {{IN_WIDTH{a[IN_WIDTH-1]}}, a};
            eb = {{IN_WIDTH{b[IN_WIDTH-1]}}, b};
        end else begin
            ea = {{IN_WIDTH{1'b0}}, a};
            eb = {{IN_WIDTH{1'b0}}, b};
        end
        return ea * eb;
    endfunction

    assign accept = EN_mult && RDY_mult;

    // Stage p0: operand registers
    logic [IN_WIDTH-1:0]  a_p0, b_p0;
    logic                 vld_p0;
    logic signed [PW-1:0] prod_p0;
    logic signed [PW-1:0] prod_last;
    logic                 vld_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p0 <= 1'b0;
        else        vld_p0 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= mult_input0;
            b_p0 <= mult_input1;
        end
    end

    assign prod_p0 = mult_full(a_p0, b_p0);

    // Stages p1..p(PIPE_STAGES-1): product delay line with parallel valid
    generate
        if (PIPE_STAGES == 1) begin : g_direct
            assign prod_last = prod_p0;
            assign vld_last  = vld_p0;
        end else begin : g_pipe
            logic signed [PW-1:0]   prod_pn [PIPE_STAGES-1];
            logic [PIPE_STAGES-2:0] vld_pn;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pn <= '0;
                end else begin
                    vld_pn[0] <= vld_p0;
                    for (int i = 1; i < PIPE_STAGES - 1; i++) vld_pn[i] <= vld_pn[i-1];
                end
            end

            always_ff @(posedge clk) begin
                prod_pn[0] <= prod_p0;
                for (int i = 1; i < PIPE_STAGES - 1; i++) prod_pn[i] <= prod_pn[i-1];
            end

            assign prod_last = prod_pn[PIPE_STAGES-2];
            assign vld_last  = vld_pn[PIPE_STAGES-2];
        end
    endgenerate

    assign wr_fire = vld_last && (state == FILL);
    assign rd_last = (({1'b0, readMem_addr} + CNT_ONE) == fill_count);

    always_comb begin
        state_next   = state;
        acc_next     = acc_cnt;
        flushed_next = flushed;
        rdy_next     = 1'b0;
        if (accept) acc_next = acc_cnt + CNT_ONE;
        case (state)
            IDLE: if (accept) state_next = FILL;
            FILL: begin
                if (flush_in) flushed_next = 1'b1;
                // fill_count already counts the write on the bus, so equality means the pipe is empty
                if ((fill_count == acc_cnt) && ((acc_cnt == DEPTH_CNT) || flushed))
                    state_next = FULL;
            end
            FULL: if (EN_blockRead) state_next = READ;
            READ: begin
                if (VALID_memVal && !EN_readMem) begin
                    state_next   = IDLE;
                    acc_next     = '0;
                    flushed_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        case (state_next)
            IDLE:    rdy_next = 1'b1;
            FILL:    rdy_next = (acc_next != DEPTH_CNT) && !flushed_next;
            default: rdy_next = 1'b0;
        endcase
    end

    // Output stage: write port, read port and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc_cnt       <= '0;
            flushed       <= 1'b0;
            RDY_mult      <= 1'b0;
            EN_writeMem   <= 1'b0;
            writeMem_addr <= '0;
            writeMem_val  <= '0;
            fill_count    <= '0;
            EN_readMem    <= 1'b0;
            readMem_addr  <= '0;
            VALID_memVal  <= 1'b0;
        end else begin
            state        <= state_next;
            acc_cnt      <= acc_next;
            flushed      <= flushed_next;
            RDY_mult     <= rdy_next;
            EN_writeMem  <= wr_fire;
            VALID_memVal <= EN_readMem;
            if (wr_fire) begin
                writeMem_addr <= fill_count[LOGDEPTH-1:0];
                writeMem_val  <= prod_last;
            end
            if ((state == READ) && (state_next == IDLE))
                fill_count <= '0;
            else if (wr_fire && (fill_count != DEPTH_CNT))
                fill_count <= fill_count + CNT_ONE;
            if ((state == FULL) && (state_next == READ)) begin
                EN_readMem   <= 1'b1;
                readMem_addr <= '0;
            end else if (EN_readMem) begin
                if (rd_last) EN_readMem <= 1'b0;
                else         readMem_addr <= readMem_addr + 1'b1;
            end
        end
    end

    // Read data arrives one cycle after the strobe, aligned with the registered valid
    assign memVal_data = VALID_memVal ? readMem_val : '0;

endmodule

// File: tb/tb_mult_block_buffer.sv
// Randomised bench for mult_block_buffer: an unsigned and a signed instance share all stimulus
// and are compared against an accept-order queue of arithmetic products.
`timescale 1ns/1ps
module tb_mult_block_buffer;
    localparam int IW    = 16;
    localparam int LD    = 6;
    localparam int PS    = 3;
    localparam int PW    = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          en_mult = 1'b0;
    logic [IW-1:0] in0 = '0, in1 = '0;
    logic          en_block_read = 1'b0;
`ifdef MULT_FLUSH_EN
    logic          flush = 1'b0;
`endif

    logic          rdy_u, wr_en_u, rd_en_u, vld_u;
    logic [LD-1:0] wr_addr_u, rd_addr_u;
    logic [PW-1:0] wr_val_u, data_u;
    logic [PW-1:0] rd_val_u = '0;
    logic [LD:0]   fc_u;
    logic          rdy_s, wr_en_s, rd_en_s, vld_s;
    logic [LD-1:0] wr_addr_s, rd_addr_s;
    logic [PW-1:0] wr_val_s, data_s;
    logic [PW-1:0] rd_val_s = '0;
    logic [LD:0]   fc_s;

    mult_block_buffer #(.IN_WIDTH(IW), .LOGDEPTH(LD), .PIPE_STAGES(PS), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .EN_mult(en_mult), .mult_input0(in0), .mult_input1(in1),
        .RDY_mult(rdy_u), .EN_writeMem(wr_en_u), .writeMem_addr(wr_addr_u), .writeMem_val(wr_val_u),
        .EN_blockRead(en_block_read), .EN_readMem(rd_en_u), .readMem_addr(rd_addr_u),
        .readMem_val(rd_val_u), .VALID_memVal(vld_u), .memVal_data(data_u), .fill_count(fc_u)
`ifdef MULT_FLUSH_EN
        , .flush(flush)
`endif
    );

    mult_block_buffer #(.IN_WIDTH(IW), .LOGDEPTH(LD), .PIPE_STAGES(PS), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .EN_mult(en_mult), .mult_input0(in0), .mult_input1(in1),
        .RDY_mult(rdy_s), .EN_writeMem(wr_en_s), .writeMem_addr(wr_addr_s), .writeMem_val(wr_val_s),
        .EN_blockRead(en_block_read), .EN_readMem(rd_en_s), .readMem_addr(rd_addr_s),
        .readMem_val(rd_val_s), .VALID_memVal(vld_s), .memVal_data(data_s), .fill_count(fc_s)
`ifdef MULT_FLUSH_EN
        , .flush(flush)
`endif
    );

    // External block memory: each word reads back as three times its address
    always @(posedge clk) begin
        if (rd_en_u) rd_val_u <= PW'(rd_addr_u) * 32'd3;
        if (rd_en_s) rd_val_s <= PW'(rd_addr_s) * 32'd3;
    end

    typedef struct {
        logic [PW-1:0] pu;
        logic [PW-1:0] ps;
        int            cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   wcount = 0;
    int   m_acc = 0;
    bit   m_flushed = 1'b0;
    bit   reading = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Every write must match the oldest outstanding accept in address, value and timing
    always @(negedge clk) begin
        if (wr_en_u) begin
            if (q.size() == 0) begin
                chk("stray_wr", 64'(1), 64'(0));
            end else begin
                mon_e = q.pop_front();
                chk("wr_addr", 64'(wr_addr_u), 64'(wcount));
                chk("wr_val_u", 64'(wr_val_u), 64'(mon_e.pu));
                chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("wr_en_s", 64'(wr_en_s), 64'(1));
                chk("wr_val_s", 64'(wr_val_s), 64'(mon_e.ps));
                wcount++;
            end
        end else if (wr_en_s) begin
            chk("stray_wr_s", 64'(1), 64'(0));
        end
        if (rd_en_u && !reading) chk("stray_rd", 64'(1), 64'(0));
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rdy"}, 64'(rdy_u), 64'(0));
        chk({tag, "_wr_en"}, 64'(wr_en_u), 64'(0));
        chk({tag, "_wr_addr"}, 64'(wr_addr_u), 64'(0));
        chk({tag, "_wr_val"}, 64'(wr_val_u), 64'(0));
        chk({tag, "_rd_en"}, 64'(rd_en_u), 64'(0));
        chk({tag, "_rd_addr"}, 64'(rd_addr_u), 64'(0));
        chk({tag, "_vld"}, 64'(vld_u), 64'(0));
        chk({tag, "_data"}, 64'(data_u), 64'(0));
        chk({tag, "_fc"}, 64'(fc_u), 64'(0));
    endtask

    // mode 0: back-to-back A=i,B=i+1; mode 1: every other cycle; mode 2: random gaps
    task automatic fill(input int mode, input int n, input bit ffff_first);
        logic [IW-1:0] a, b;
        bit en, exp_rdy;
        int sa, sb;
        exp_t e;
        m_acc = 0;
        m_flushed = 1'b0;
        wcount = 0;
        for (int c = 0; c < 1000 && m_acc < n; c++) begin
            @(negedge clk);
            exp_rdy = (m_acc < DEPTH) && !m_flushed;
            chk("rdy_fill", 64'(rdy_u), 64'(exp_rdy));
            chk("rdy_fill_s", 64'(rdy_s), 64'(exp_rdy));
            case (mode)
                0:       en = 1'b1;
                1:       en = (c % 2 == 0);
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 0) begin
                a = IW'(m_acc);
                b = IW'(m_acc + 1);
            end else begin
                a = IW'($urandom);
                b = IW'($urandom);
            end
            if (ffff_first && m_acc == 0) begin
                a = 16'hFFFF;
                b = 16'h0002;
            end
            en_block_read = (c == 5);
            en_mult = en;
            in0 = a;
            in1 = b;
            if (en && exp_rdy) begin
                sa = int'($signed(a));
                sb = int'($signed(b));
                e.pu = PW'(a) * PW'(b);
                e.ps = PW'(sa * sb);
                e.cyc = cyc + 1 + PS;
                q.push_back(e);
                m_acc++;
            end
        end
    endtask

    // Offered operands must be ignored once the block is closed; then wait for the pipe to drain
    task automatic post_full(input int n);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
`ifdef MULT_FLUSH_EN
            flush = 1'b0;
`endif
            en_block_read = 1'b0;
            chk("rdy_closed", 64'(rdy_u), 64'(0));
            en_mult = 1'b1;
            in0 = IW'($urandom);
            in1 = IW'($urandom);
        end
        @(negedge clk);
        en_mult = 1'b0;
        for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
        chk("drain", 64'(q.size()), 64'(0));
        repeat (2) @(negedge clk);
        chk("write_count", 64'(wcount), 64'(n));
        chk("fill_count", 64'(fc_u), 64'(n));
        chk("fill_count_s", 64'(fc_s), 64'(n));
        chk("rdy_full", 64'(rdy_u), 64'(0));
        chk("wr_idle", 64'(wr_en_u), 64'(0));
    endtask

    task automatic read_block(input int n);
        int start, ridx, vidx;
        ridx = 0;
        vidx = 0;
        @(negedge clk);
        en_block_read = 1'b1;
        reading = 1'b1;
        start = cyc + 1;
        for (int k = 0; k < n + 20 && vidx < n; k++) begin
            @(negedge clk);
            en_block_read = 1'b0;
            en_mult = 1'($urandom_range(0, 1));
            in0 = IW'($urandom);
            in1 = IW'($urandom);
            if (rd_en_u) begin
                chk("rd_addr", 64'(rd_addr_u), 64'(ridx));
                chk("rd_cycle", 64'(cyc), 64'(start + ridx));
                ridx++;
            end
            if (vld_u) begin
                chk("rd_data", 64'(data_u), 64'(vidx * 3));
                chk("rd_data_s", 64'(data_s), 64'(vidx * 3));
                chk("vld_cycle", 64'(cyc), 64'(start + 1 + vidx));
                vidx++;
            end
        end
        chk("rd_count", 64'(ridx), 64'(n));
        chk("vld_count", 64'(vidx), 64'(n));
        @(negedge clk);
        en_mult = 1'b0;
        chk("rdy_after_read", 64'(rdy_u), 64'(1));
        chk("fc_after_read", 64'(fc_u), 64'(0));
        chk("rd_en_after_read", 64'(rd_en_u), 64'(0));
        chk("vld_after_read", 64'(vld_u), 64'(0));
        reading = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        #23;
        check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        fill(0, DEPTH, 1'b0);
        post_full(DEPTH);
        read_block(DEPTH);

        fill(1, DEPTH, 1'b1);
        post_full(DEPTH);
        read_block(DEPTH);

        fill(2, 20, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        en_mult = 1'b0;
        #1;
        check_zero("mid_rst");
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fill(2, DEPTH, 1'b0);
        post_full(DEPTH);
        read_block(DEPTH);

`ifdef MULT_FLUSH_EN
        fill(2, 10, 1'b0);
        @(negedge clk);
        en_mult = 1'b0;
        flush = 1'b1;
        m_flushed = 1'b1;
        post_full(10);
        read_block(10);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
